// File: rtl/cond_logic_if.sv
// ============================================================================
// Module      : cond_logic_if
// Description : Instruction-side bus for the conditional-execution unit:
//               decode/ALU requests in, gated writes, flags and counters out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cond_logic_if #(
    parameter int CW = 16
);
    logic          valid;
    logic          stall;
    logic [3:0]    cond;
    logic [3:0]    alu_flags;
    logic [1:0]    flag_w;
    logic          pcs;
    logic          reg_w;
    logic          mem_w;
    logic          no_write;

    logic          cond_ex;
    logic          pc_src;
    logic          reg_write;
    logic          mem_write;
    logic [3:0]    flags;
    logic [CW-1:0] exec_cnt;
    logic [CW-1:0] squash_cnt;

    modport master (
        output valid, stall, cond, alu_flags, flag_w, pcs, reg_w, mem_w, no_write,
        input  cond_ex, pc_src, reg_write, mem_write, flags, exec_cnt, squash_cnt
    );

    modport slave (
        input  valid, stall, cond, alu_flags, flag_w, pcs, reg_w, mem_w, no_write,
        output cond_ex, pc_src, reg_write, mem_write, flags, exec_cnt, squash_cnt
    );
endinterface

`default_nettype wire

// File: rtl/cond_logic.sv
// ============================================================================
// Module      : cond_logic
// Description : ARM-style condition evaluation against stored NZCV flags,
//               write gating and saturating executed/squashed counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_logic #(
    parameter int CW = 16
) (
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus
);

    localparam logic [3:0] c_EQ = 4'b0000;
    localparam logic [3:0] c_NE = 4'b0001;
    localparam logic [3:0] c_CS = 4'b0010;
    localparam logic [3:0] c_CC = 4'b0011;
    localparam logic [3:0] c_MI = 4'b0100;
    localparam logic [3:0] c_PL = 4'b0101;
    localparam logic [3:0] c_VS = 4'b0110;
    localparam logic [3:0] c_VC = 4'b0111;
    localparam logic [3:0] c_HI = 4'b1000;
    localparam logic [3:0] c_LS = 4'b1001;
    localparam logic [3:0] c_GE = 4'b1010;
    localparam logic [3:0] c_LT = 4'b1011;
    localparam logic [3:0] c_GT = 4'b1100;
    localparam logic [3:0] c_LE = 4'b1101;
    localparam logic [3:0] c_AL = 4'b1110;

    logic [3:0]    r_flags;
    logic [CW-1:0] r_exec_cnt;
    logic [CW-1:0] r_squash_cnt;

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_cond_ex;
    logic w_commit;
    logic w_exec;
    logic w_squash;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Evaluated from the registered flags only, so a flag-setting instruction
    // never sees its own ALU result.
    always_comb begin
        w_cond_ex = 1'b0;
        case (bus.cond)
            c_EQ:    w_cond_ex = w_z;
            c_NE:    w_cond_ex = ~w_z;
            c_CS:    w_cond_ex = w_c;
            c_CC:    w_cond_ex = ~w_c;
            c_MI:    w_cond_ex = w_n;
            c_PL:    w_cond_ex = ~w_n;
            c_VS:    w_cond_ex = w_v;
            c_VC:    w_cond_ex = ~w_v;
            c_HI:    w_cond_ex = w_c & ~w_z;
            c_LS:    w_cond_ex = ~w_c | w_z;
            c_GE:    w_cond_ex = w_n ~^ w_v;
            c_LT:    w_cond_ex = w_n ^ w_v;
            c_GT:    w_cond_ex = ~w_z & (w_n ~^ w_v);
            c_LE:    w_cond_ex = w_z | (w_n ^ w_v);
            c_AL:    w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    assign w_commit = bus.valid & ~bus.stall;
    assign w_exec   = w_commit & w_cond_ex;
    assign w_squash = w_commit & ~w_cond_ex;

    assign bus.cond_ex    = w_cond_ex;
    assign bus.pc_src     = w_exec & bus.pcs;
    assign bus.reg_write  = w_exec & bus.reg_w & ~bus.no_write;
    assign bus.mem_write  = w_exec & bus.mem_w;
    assign bus.flags      = r_flags;
    assign bus.exec_cnt   = r_exec_cnt;
    assign bus.squash_cnt = r_squash_cnt;

    // NZ and CV groups load independently; reset discards a coincident commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (w_exec && bus.flag_w[1]) begin
                r_flags[3:2] <= bus.alu_flags[3:2];
            end
            if (w_exec && bus.flag_w[0]) begin
                r_flags[1:0] <= bus.alu_flags[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exec_cnt   <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (w_exec && (r_exec_cnt != '1)) begin
                r_exec_cnt <= r_exec_cnt + CW'(1);
            end
            if (w_squash && (r_squash_cnt != '1)) begin
                r_squash_cnt <= r_squash_cnt + CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 SHALL have parameter CW, default 16, giving the width of each performance counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port valid  input  1  current instruction is live this cycle.
REQ-005 SHALL have port stall  input  1  pipeline hold; the instruction is not committed this cycle.
REQ-006 SHALL have port cond  input  4  condition field of the current instruction.
REQ-007 SHALL have port alu_flags  input  4  ALU result flags {N,Z,C,V}, MSB = N.
REQ-008 SHALL have port flag_w  input  2  flag-write request; bit1 = NZ group, bit0 = CV group.
REQ-009 SHALL have port pcs  input  1  instruction writes PC (branch or PC destination).
REQ-010 SHALL have port reg_w  input  1  instruction requests a register-file write.
REQ-011 SHALL have port mem_w  input  1  instruction requests a memory write.
REQ-012 SHALL have port no_write  input  1  compare-type instruction; suppress the register write.
REQ-013 SHALL have port cond_ex  output  1  condition passes against the stored flags.
REQ-014 SHALL have port pc_src  output  1  gated PC write.
REQ-015 SHALL have port reg_write  output  1  gated register-file write.
REQ-016 SHALL have port mem_write  output  1  gated memory write.
REQ-017 SHALL have port flags  output  4  stored {N,Z,C,V}.
REQ-018 SHALL have port exec_cnt  output  CW  count of committed instructions whose condition passed.
REQ-019 SHALL have port squash_cnt  output  CW  count of committed instructions whose condition failed.

Function
REQ-020 SHALL evaluate cond_ex combinationally from cond and the stored flags, never from alu_flags.
REQ-021 Condition table, part 1: 0000 = Z; 0001 = ~Z; 0010 = C; 0011 = ~C; 0100 = N; 0101 = ~N; 0110 = V; 0111 = ~V.
REQ-022 Condition table, part 2: 1000 = C&~Z; 1001 = ~C|Z; 1010 = N~^V; 1011 = N^V; 1100 = ~Z&(N~^V); 1101 = Z|(N^V); 1110 = 1; 1111 = 0 (reserved, never executes).
REQ-023 SHALL define commit = valid & ~stall.
REQ-024 SHALL drive the gated outputs combinationally as:
- pc_src = commit & pcs & cond_ex
- reg_write = commit & reg_w & ~no_write & cond_ex
- mem_write = commit & mem_w & cond_ex
REQ-025 SHALL load flags[3:2] from alu_flags[3:2] on the clock edge when commit & flag_w[1] & cond_ex.
REQ-026 SHALL load flags[1:0] from alu_flags[1:0] on the clock edge when commit & flag_w[0] & cond_ex.
REQ-027 SHALL leave flags unchanged in every other case, including either group when its flag_w bit is 0.
REQ-028 SHALL make updated flags visible to cond_ex only from the next cycle (1-cycle latency; no bypass).
REQ-029 SHALL increment exec_cnt by 1 on each commit with cond_ex = 1.
REQ-030 SHALL increment squash_cnt by 1 on each commit with cond_ex = 0.
REQ-031 Each counter SHALL saturate at all-ones and hold there; it SHALL never wrap.
REQ-032 When stall = 1 or valid = 0: no flag update, no counter change, and all gated outputs = 0.
REQ-033 Simultaneous flag update and evaluation: an instruction that passes and sets flags is evaluated against the old flags; the new flags apply to the following instruction.

Reset
REQ-034 On a clock edge with reset = 1: flags = 4'b0000, exec_cnt = 0, squash_cnt = 0.
REQ-035 Reset SHALL take priority over any simultaneous commit; that instruction's flag and counter updates are discarded.
REQ-036 While reset is high, gated outputs SHALL still follow REQ-024 combinationally; with flags = 0000, cond 0000 yields cond_ex = 0.

Verification
REQ-037 Reset then cond=1110, valid=1, reg_w=1 -> cond_ex=1, reg_write=1; next cycle exec_cnt=1.
REQ-038 flags=0000; cond=1110, flag_w=11, alu_flags=0100, valid=1 -> next cycle flags=0100; then cond=0000 (EQ) -> cond_ex=1; cond=0001 (NE) -> cond_ex=0, squash_cnt incremented.
REQ-039 flags=1000 (N=1, V=0); cond=1011 (LT), pcs=1 -> pc_src=1; cond=1010 (GE), mem_w=1 -> mem_write=0, flags unchanged.
REQ-040 Passing instruction with flag_w=10, alu_flags=0011, starting from flags=0000 -> flags stay 0000 (CV group not written); stall=1 with flag_w=11 -> no change, counters unchanged.
REQ-041 CW=4, 17 consecutive passing commits -> exec_cnt=4'hF and holds; reset asserted together with a commit -> counters=0, flags=0000 next cycle.
REQ-042 cond=1110, reg_w=1, no_write=1, flag_w=11 -> reg_write=0, flags updated next cycle, exec_cnt incremented.
